// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SELECTED = 1'b1
  } spi_state_t;

  localparam int SPI_WORD_WIDTH  = 16;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_if.sv
// SPI pins plus the word-level transmit/receive handshake and sticky status.
interface spi_if import spi_pkg::*; #(
  parameter int WORD_WIDTH = SPI_WORD_WIDTH
) ();

  logic                  spi_sck;
  logic                  spi_ss_n;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  underrun;
  logic                  frame_err;
  logic                  status_clr;

  modport slave (
    input  spi_sck, spi_ss_n, spi_mosi, tx_data, tx_valid, status_clr,
    output spi_miso, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );

  modport master (
    output spi_sck, spi_ss_n, spi_mosi, tx_data, tx_valid, status_clr,
    input  spi_miso, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );

endinterface

// File: rtl/spi_sync.sv
// N-stage synchroniser with a registered copy for rise/fall detection.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      q     <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q     <= chain[STAGES-1];
    end
  end

  assign s    = chain[STAGES-1];
  assign rise = s & ~q;
  assign fall = ~s & q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversampled pins, one-entry tx holding buffer, rx valid pulses.
//   state    | meaning
//   IDLE     | not selected; waiting for ss_n low
//   SELECTED | shifting words; rise samples mosi, fall advances miso
module spi_slave import spi_pkg::*; #(
  parameter int WORD_WIDTH  = SPI_WORD_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic   clk,
  input  logic   rst,
  spi_if.slave   bus
);

  localparam int                BW   = $clog2(WORD_WIDTH);
  localparam logic [BW-1:0]     LAST = BW'(WORD_WIDTH - 1);

  spi_state_t            state;
  logic [BW-1:0]         bitcount;
  logic [WORD_WIDTH-1:0] rx_sh;
  logic [WORD_WIDTH-1:0] tx_sh;
  logic [WORD_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  underrun;
  logic                  frame_err;
  logic                  pend_underrun;

  logic                   sck_s, sck_rise, sck_fall;
  logic                   ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_s;
  logic                   accept;
  logic                   unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d   (bus.spi_sck),
    .s   (sck_s),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk (clk),
    .rst (rst),
    .d   (bus.spi_ss_n),
    .s   (ss_s),
    .rise(ss_rise),
    .fall(ss_fall)
  );

  assign unused = ^{sck_s, ss_rise, ss_fall};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_chain <= '0;
    else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign mosi_s = mosi_chain[SYNC_STAGES-1];
  assign accept = bus.tx_valid & ~buf_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bitcount      <= '0;
      rx_sh         <= '0;
      tx_sh         <= '0;
      buf_data      <= '0;
      buf_full      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      underrun      <= 1'b0;
      frame_err     <= 1'b0;
      pend_underrun <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Clear first so that any set event later in this block wins.
      if (bus.status_clr) begin
        underrun  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (accept) begin
        buf_data <= bus.tx_data;
        buf_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!ss_s) begin
            state         <= SELECTED;
            bitcount      <= '0;
            pend_underrun <= 1'b0;
            if (buf_full) begin
              tx_sh    <= buf_data;
              buf_full <= 1'b0;
            end else begin
              tx_sh    <= '0;
              underrun <= 1'b1;
            end
          end
        end
        SELECTED: begin
          if (ss_s) begin
            state         <= IDLE;
            bitcount      <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            pend_underrun <= 1'b0;
            if (bitcount != '0) frame_err <= 1'b1;
          end else if (sck_rise) begin
            rx_sh <= {rx_sh[WORD_WIDTH-2:0], mosi_s};
            if (bitcount == LAST) begin
              rx_data  <= {rx_sh[WORD_WIDTH-2:0], mosi_s};
              rx_valid <= 1'b1;
              bitcount <= '0;
            end else begin
              bitcount <= bitcount + 1'b1;
            end
            // A boundary reload from an empty buffer only counts once the next word really starts.
            if (pend_underrun) begin
              underrun      <= 1'b1;
              pend_underrun <= 1'b0;
            end
          end else if (sck_fall) begin
            if (bitcount != '0) begin
              tx_sh <= {tx_sh[WORD_WIDTH-2:0], 1'b0};
            end else if (buf_full) begin
              tx_sh    <= buf_data;
              buf_full <= 1'b0;
            end else begin
              tx_sh         <= '0;
              pend_underrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso  = (state == SELECTED) ? tx_sh[WORD_WIDTH-1] : 1'b0;
  assign bus.tx_ready  = ~buf_full;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.busy      = (state == SELECTED);
  assign bus.underrun  = underrun;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bench-side SPI initiator with hand-computed expectations.
module tb_spi_slave;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [15:0] rxq[$];
  logic [15:0] got, got2;

  spi_if bus ();

  spi_slave dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.rx_valid) rxq.push_back(bus.rx_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [15:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic frame_begin();
    @(negedge clk);
    bus.spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    bus.spi_ss_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] out, input int nbits, output logic [15:0] in);
    in = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.spi_mosi = out[15-i];
      repeat (HALF) @(negedge clk);
      in = {in[14:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.status_clr = 1'b1;
    @(negedge clk);
    bus.status_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.spi_sck    = 1'b0;
    bus.spi_ss_n   = 1'b1;
    bus.spi_mosi   = 1'b0;
    bus.tx_data    = '0;
    bus.tx_valid   = 1'b0;
    bus.status_clr = 1'b0;

    // Reset held over random pin activity
    repeat (40) begin
      @(negedge clk);
      bus.spi_sck  = 1'($urandom_range(0, 1));
      bus.spi_ss_n = 1'($urandom_range(0, 1));
      bus.spi_mosi = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.spi_sck  = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    chk("rst_miso",      32'(bus.spi_miso),  32'h0);
    chk("rst_tx_ready",  32'(bus.tx_ready),  32'h1);
    chk("rst_rx_data",   32'(bus.rx_data),   32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_underrun",  32'(bus.underrun),  32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_no_rxv",    32'(rxq.size()),    32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single word
    push_tx(16'hA5C3);
    chk("single_tx_ready_full", 32'(bus.tx_ready), 32'h0);
    frame_begin();
    chk("single_busy",     32'(bus.busy),     32'h1);
    chk("single_tx_ready", 32'(bus.tx_ready), 32'h1);
    xfer(16'h1234, 16, got);
    frame_end();
    chk("single_rx_count",  32'(rxq.size()),    32'd1);
    chk("single_rx_data",   32'(bus.rx_data),   32'h1234);
    chk("single_miso_word", 32'(got),           32'hA5C3);
    chk("single_underrun",  32'(bus.underrun),  32'h0);
    chk("single_tx_ready2", 32'(bus.tx_ready),  32'h1);
    chk("single_busy_end",  32'(bus.busy),      32'h0);

    // Burst of two words
    push_tx(16'h0F0F);
    frame_begin();
    push_tx(16'hF00F);
    xfer(16'hBEEF, 16, got);
    xfer(16'hCAFE, 16, got2);
    frame_end();
    chk("burst_rx_count", 32'(rxq.size()),   32'd3);
    chk("burst_rx0",      32'(rxq[1]),       32'hBEEF);
    chk("burst_rx1",      32'(rxq[2]),       32'hCAFE);
    chk("burst_miso0",    32'(got),          32'h0F0F);
    chk("burst_miso1",    32'(got2),         32'hF00F);
    chk("burst_underrun", 32'(bus.underrun), 32'h0);

    // Underrun: buffer empty at select
    frame_begin();
    chk("ur_flag_at_select", 32'(bus.underrun), 32'h1);
    xfer(16'h1111, 16, got);
    frame_end();
    chk("ur_miso_zero", 32'(got),         32'h0000);
    chk("ur_rx_data",   32'(rxq[3]),      32'h1111);
    pulse_clr();
    chk("ur_cleared",   32'(bus.underrun), 32'h0);

    // Abort after 7 bits, then a clean frame
    frame_begin();
    xfer(16'hFFFF, 7, got);
    frame_end();
    chk("abort_no_rxv",    32'(rxq.size()),    32'd4);
    chk("abort_frame_err", 32'(bus.frame_err), 32'h1);
    chk("abort_busy",      32'(bus.busy),      32'h0);
    chk("abort_rx_held",   32'(bus.rx_data),   32'h1111);
    push_tx(16'h3C3C);
    frame_begin();
    xfer(16'h5555, 16, got);
    frame_end();
    chk("after_abort_rx",   32'(rxq[4]), 32'h5555);
    chk("after_abort_miso", 32'(got),    32'h3C3C);
    pulse_clr();
    chk("abort_cleared",    32'(bus.frame_err), 32'h0);

    // Reset asserted mid-frame
    frame_begin();
    xfer(16'hFFFF, 9, got);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    chk("midrst_rx_data", 32'(bus.rx_data), 32'h0);
    chk("midrst_busy",    32'(bus.busy),    32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_rxv",  32'(rxq.size()),  32'd5);
    push_tx(16'h1357);
    frame_begin();
    xfer(16'h8001, 16, got);
    frame_end();
    chk("midrst_rx_count", 32'(rxq.size()), 32'd6);
    chk("midrst_rx_data2", 32'(bus.rx_data), 32'h8001);
    chk("midrst_miso",     32'(got),         32'h1357);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0, MSB first, 16-bit words) for the wishbone-side SPI subsystem.
- Lets an external or on-board SPI initiator exchange words with FPGA logic.
- SPI pins are oversampled and synchronised into the single system clock.
- Transmit side is a one-entry holding buffer with a valid/ready handshake; receive side emits one-cycle valid pulses. A wishbone register wrapper sits above it.

Parameters:
- WORD_WIDTH, 16, bits per SPI word; also the width of tx_data and rx_data.
- SYNC_STAGES, 2, flip-flop stages on spi_sck, spi_mosi and spi_ss_n (minimum 2).

Ports:
- clk  input  1  system clock; everything is synchronous to its rising edge.
- rst  input  1  asynchronous, active-high reset.
- spi_sck  input  1  SPI clock from the initiator; idles low.
- spi_ss_n  input  1  slave select, active low.
- spi_mosi  input  1  data from the initiator.
- spi_miso  output  1  data to the initiator; shift register MSB while selected, 0 otherwise.
- tx_data  input  WORD_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding buffer is empty; a word is accepted when tx_valid and tx_ready are both high.
- rx_data  output  WORD_WIDTH  last complete received word; holds until the next word completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high while in state SELECTED.
- underrun  output  1  sticky: a word boundary occurred with the holding buffer empty.
- frame_err  output  1  sticky: spi_ss_n deasserted mid-word.
- status_clr  input  1  clears underrun and frame_err; a set event in the same cycle wins.

Behaviour:
- Reset values:
  - Outputs: spi_miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0.
  - Internal: synchroniser outputs sck=0, ss_n=1, mosi=0; state IDLE; bitcount=0; shift registers=0; buffer empty.
- Edge detection: rise = sck_s & ~sck_q and fall = ~sck_s & sck_q, taken on the synchronised signals.
- Timing requirement on the initiator: SCK high and low phases each last at least SYNC_STAGES+2 clk cycles. For a same-clock initiator driven through its divisor register, the divisor must be at least 3.
- State IDLE (entered from reset):
  - On synchronised ss_n low, go to SELECTED.
  - In that same cycle: bitcount=0; tx shifter loads the buffer word and the buffer empties.
  - If the buffer is empty, the shifter loads 0 and underrun is set.
- State SELECTED:
  - On rise: rx shifter takes {rx_sh[W-2:0], mosi_s} and bitcount increments.
  - When bitcount==W-1 at a rise:
    - rx_data takes {rx_sh[W-2:0], mosi_s} on that same edge.
    - rx_valid is high for the next cycle only.
    - bitcount wraps to 0.
  - On fall with bitcount!=0: tx shifter shifts left by one, filling with 0.
  - On fall with bitcount==0 (word boundary, burst continues): tx shifter reloads from the buffer, with the same empty/underrun rule as at select.
  - ss_n high: go to IDLE.
    - If bitcount!=0: set frame_err, discard the partial rx word (no rx_valid), and drop the partially sent tx word.
    - The holding buffer is never affected by an abort.
- Holding buffer:
  - A write in the same cycle as a load from an empty buffer is captured for the next word; underrun is still set for the current word.
  - tx_ready rises the cycle after the buffer is consumed.
- Reset asserted mid-frame returns to the reset values immediately; no rx_valid is generated.
- The first falling edge cannot precede the first rising edge (mode 0), so no fall handling is needed before the first bit.

Decomposition:
- Package spi_pkg holds:
  - state encodings: IDLE=1'b0, SELECTED=1'b1;
  - SPI_WORD_WIDTH=16 default;
  - SPI_SYNC_STAGES=2 default.
- Sub-module spi_sync: N-stage synchroniser with a registered copy and rise/fall outputs. Instantiated for spi_sck and spi_ss_n; spi_mosi uses the plain synchroniser output.

Test Plan:
- Reset: all outputs at their reset values, including spi_miso=0 and tx_ready=1; hold rst over random pin activity -> no rx_valid.
- Single word:
  - Stimulus: tx_data=16'hA5C3 loaded; initiator with divisor=3 sends 16'h1234.
  - Required: exactly one rx_valid with rx_data=16'h1234; initiator's rx_register=16'hA5C3; tx_ready=1 from the select cycle onward; underrun=0.
- Burst:
  - Stimulus: ss_n held low for two words; buffer preloaded with 16'h0F0F, then 16'hF00F written during word one; initiator sends 16'hBEEF, 16'hCAFE.
  - Required: rx_valid pulses with 16'hBEEF then 16'hCAFE; initiator receives 16'h0F0F then 16'hF00F.
- Underrun: buffer empty at select -> initiator receives 16'h0000, underrun=1; status_clr pulse -> underrun=0.
- Abort: ss_n deasserted after 7 bits -> no rx_valid, frame_err=1, busy=0; the next full frame 16'h5555 is received correctly.
- Reset mid-frame: rst asserted after 9 bits, then a clean frame of 16'h8001 -> rx_data=16'h8001, no stale bits.
